fft_bin_sequencer: RTL
======================

FFT_BIN_SEQUENCER -- requirements
Module: fft_bin_sequencer

Interface
REQ-001 SHALL have parameter SETTLE, default 2: clk cycles between a sel change and sampling of the FFT outputs; legal range 1..15.
REQ-002 SHALL have parameter W, default 12: width of the FFT real and imaginary outputs.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request one full 8-bin readout.
REQ-006 SHALL have port sel, output, 3 bits: bin select driven to the dit_fft core.
REQ-007 SHALL have ports fft_yr and fft_yi, input, W bits each: real and imaginary output of the dit_fft core for the current sel.
REQ-008 SHALL have port out_valid, output, 1 bit: the output beat is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the beat.
REQ-010 SHALL have ports out_re and out_im, output, W bits each: captured bin value.
REQ-011 SHALL have port out_idx, output, 3 bits: bin index of the current beat.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse after the last beat is accepted.

Function
REQ-014 SHALL implement an FSM with states IDLE, SETTLE, HOLD and DONE.
REQ-015 IDLE: when start=1 at an edge -> sel<=0, settle counter<=0, state<=SETTLE (start accepted).
REQ-016 start SHALL be ignored in every state except IDLE, with no queuing.
REQ-017 SETTLE: the counter SHALL increment each cycle.
REQ-018 SETTLE: at the edge where counter==SETTLE-1 -> out_re<=fft_yr, out_im<=fft_yi, out_idx<=sel, out_valid<=1, state<=HOLD; that edge is exactly SETTLE edges after sel changed.
REQ-019 HOLD: out_valid, out_re, out_im, out_idx and sel SHALL stay stable until out_valid&&out_ready at an edge.
REQ-020 HOLD handshake when sel<7 -> out_valid<=0, sel<=sel+1, counter<=0, state<=SETTLE.
REQ-021 HOLD handshake when sel==7 -> out_valid<=0, state<=DONE; sel stays 7.
REQ-022 DONE: done=1 for exactly one cycle, then state<=IDLE; start is not accepted in DONE.
REQ-023 Bins SHALL be emitted in order 0..7, exactly once each per start, with no wrap past 7.
REQ-024 With out_ready held high, a readout SHALL take (SETTLE+1)*8 cycles from start acceptance to the last handshake.
REQ-025 out_ready while out_valid=0 SHALL have no effect; out_valid SHALL never rise in the same cycle a handshake completes.
REQ-026 Captured data SHALL be registered copies, with no combinational path from fft_yr or fft_yi to out_re or out_im.
REQ-027 SHALL NOT perform arithmetic on the data; the settle counter SHALL be 4 bits.

Reset
REQ-028 When rst=1 at an edge, the block SHALL set state=IDLE, sel=0, out_valid=0, out_re=0, out_im=0, out_idx=0, busy=0, done=0 and counter=0.
REQ-029 rst SHALL take priority over start and over any handshake in the same cycle.
REQ-030 rst mid-readout SHALL abort the readout with no done pulse; the next start restarts at bin 0.

Verification
REQ-031 Nominal, SETTLE=2, out_ready=1: start pulse at cycle 0 -> sel=0..7, out_valid high in cycles 2,5,...,23, out_idx 0..7, done high in cycle 24, busy low from cycle 25.
REQ-032 Backpressure: out_ready=0 for 10 cycles on bin 3 -> out_valid, out_re, out_im and out_idx=3 held constant; sel=3 throughout; bin 4 follows 3 cycles after out_ready rises.
REQ-033 Data capture: drive fft_yr=sel*100 and fft_yi=-(sel*100) (12-bit) from a model -> out_re=0,100,...,700 and out_im=0,-100,...,-700 in order.
REQ-034 Start while busy: start pulses at bins 2 and 6 -> no effect; exactly 8 beats and one done pulse.
REQ-035 Reset mid-run: rst during HOLD of bin 4 -> all outputs 0 on the next cycle and no done; a new start yields bins 0..7 again.
REQ-036 Parameter: SETTLE=1 and SETTLE=15 builds -> the beat period with out_ready=1 is 2 and 16 cycles respectively.

Source files
------------

// File: rtl/fft_bin_sequencer.sv
// Walks the dit_fft bin select through 0..7, waits a settle time per bin,
// captures the core outputs and hands each bin downstream as one beat.
module fft_bin_sequencer #(
   parameter int SETTLE = 2,
   parameter int W      = 12
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   output logic [2:0]   sel,
   input  logic [W-1:0] fft_yr,
   input  logic [W-1:0] fft_yi,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_re,
   output logic [W-1:0] out_im,
   output logic [2:0]   out_idx,
   output logic         busy,
   output logic         done,
   output logic [1:0]   dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HOLD   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [3:0] LP_CNT_LAST = 4'(SETTLE - 1);

   state_t         r_state;
   logic [3:0]     r_cnt;
   logic [2:0]     r_sel;
   logic           r_valid;
   logic [W-1:0]   r_re;
   logic [W-1:0]   r_im;
   logic [2:0]     r_idx;
   logic           r_busy;
   logic           r_done;

   // Output beat: transfers at an edge where out_valid && out_ready; while
   // out_valid is high and out_ready low, the beat and sel are held unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
         r_sel   <= 3'd0;
         r_valid <= 1'b0;
         r_re    <= '0;
         r_im    <= '0;
         r_idx   <= 3'd0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_sel   <= 3'd0;
                  r_cnt   <= 4'd0;
                  r_busy  <= 1'b1;
                  r_state <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               r_cnt <= r_cnt + 4'd1;
               // sel has been stable for SETTLE edges here; sample the core.
               if (r_cnt == LP_CNT_LAST) begin
                  r_re    <= fft_yr;
                  r_im    <= fft_yi;
                  r_idx   <= r_sel;
                  r_valid <= 1'b1;
                  r_state <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  r_valid <= 1'b0;
                  if (r_sel == 3'd7) begin
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     r_sel   <= r_sel + 3'd1;
                     r_cnt   <= 4'd0;
                     r_state <= ST_SETTLE;
                  end
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign sel       = r_sel;
   assign out_valid = r_valid;
   assign out_re    = r_re;
   assign out_im    = r_im;
   assign out_idx   = r_idx;
   assign busy      = r_busy;
   assign done      = r_done;
   assign dbg_state = r_state;

endmodule
